// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle HI/LO sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO
//
// Ports:
//   CLK  in   clock, rising edge
//   RST  in   synchronous active-low reset
//   Req  in   issue strobe (Func/A/B valid while high)
//   Func in   funct field of the issued R-form instruction
//   A    in   rs operand (multiplicand / dividend / MTHI-MTLO source)
//   B    in   rt operand (multiplier / divisor)
//   Busy out  operation in flight; requests are ignored
//   Done out  one-cycle pulse when a multiply/divide result commits
//   Hi   out  HI register
//   Lo   out  LO register
module muldiv_seq #(
    parameter int         XLEN    = 32,
    parameter logic [5:0] F_MTHI  = 6'h11,
    parameter logic [5:0] F_MTLO  = 6'h13,
    parameter logic [5:0] F_MULT  = 6'h18,
    parameter logic [5:0] F_MULTU = 6'h19,
    parameter logic [5:0] F_DIV   = 6'h1A,
    parameter logic [5:0] F_DIVU  = 6'h1B
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Req,
    input  logic [5:0]      Func,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Hi,
    output logic [XLEN-1:0] Lo
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    // MUL: {partial product high, multiplier shifting out}
    // DIV: {partial remainder, dividend shifting out / quotient shifting in}
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic                is_div_q, is_div_d;
    logic                pneg_q, pneg_d;     // negate product / quotient
    logic                rneg_q, rneg_d;     // negate remainder
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;
    logic                done_q, done_d;

    logic [XLEN:0]       madd;
    logic [XLEN:0]       dshift;
    logic [XLEN+1:0]     dsub;
    logic                dge;
    logic                sa, sb;
    logic [2*XLEN-1:0]   prod_neg;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign madd     = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    assign dshift   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign dsub     = {1'b0, dshift} - {2'b00, opnd_q};
    assign dge      = ~dsub[XLEN+1];
    assign prod_neg = ~acc_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        pneg_d   = pneg_q;
        rneg_d   = rneg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        sa       = 1'b0;
        sb       = 1'b0;

        case (state_q)
            IDLE: begin
                if (Req) begin
                    if (Func == F_MTHI) begin
                        hi_d = A;
                    end else if (Func == F_MTLO) begin
                        lo_d = A;
                    end else if (Func == F_MULT || Func == F_MULTU) begin
                        sa       = (Func == F_MULT) & A[XLEN-1];
                        sb       = (Func == F_MULT) & B[XLEN-1];
                        acc_d    = {{XLEN{1'b0}}, mag(B, sb)};
                        opnd_d   = mag(A, sa);
                        pneg_d   = sa ^ sb;
                        rneg_d   = 1'b0;
                        is_div_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else if (Func == F_DIV || Func == F_DIVU) begin
                        sa       = (Func == F_DIV) & A[XLEN-1];
                        sb       = (Func == F_DIV) & B[XLEN-1];
                        acc_d    = {{XLEN{1'b0}}, mag(A, sa)};
                        opnd_d   = mag(B, sb);
                        // Divide by zero keeps the all-ones quotient unsigned.
                        pneg_d   = (sa ^ sb) & (B != '0);
                        rneg_d   = sa;
                        is_div_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = DIV;
                    end
                end
            end
            MUL: begin
                // Add multiplicand into the high half when the low bit is set,
                // then shift the whole accumulator right, carry included.
                if (acc_q[0]) begin
                    acc_d = {madd, acc_q[XLEN-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[2*XLEN-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            DIV: begin
                if (dge) begin
                    acc_d = {dsub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {dshift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d = mag(acc_q[XLEN-1:0], pneg_q);
                    hi_d = mag(acc_q[2*XLEN-1:XLEN], rneg_q);
                end else if (pneg_q) begin
                    hi_d = prod_neg[2*XLEN-1:XLEN];
                    lo_d = prod_neg[XLEN-1:0];
                end else begin
                    hi_d = acc_q[2*XLEN-1:XLEN];
                    lo_d = acc_q[XLEN-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            pneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            pneg_q   <= pneg_d;
            rneg_q   <= rneg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign Busy = (state_q != IDLE);
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq
module tb_muldiv_seq;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Req = 1'b0;
    logic [5:0]  Func = 6'h00;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Busy, Done;
    logic [31:0] Hi, Lo;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_seq dut (
        .CLK  (CLK),
        .RST  (RST),
        .Req  (Req),
        .Func (Func),
        .A    (A),
        .B    (B),
        .Busy (Busy),
        .Done (Done),
        .Hi   (Hi),
        .Lo   (Lo)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        Req  = 1'b1;
        Func = f;
        A    = a;
        B    = b;
        tick();
        Req  = 1'b0;
    endtask

    // Issue at edge T, watch Busy/Done/Hi/Lo through T+33, check commit at
    // T+34 and that Done drops at T+35.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int bad;
        logic [31:0] old_hi, old_lo;
        old_hi = Hi;
        old_lo = Lo;
        issue(f, a, b);
        bad = 0;
        for (int i = 1; i <= 33; i++) begin
            if (Busy !== 1'b1 || Done !== 1'b0 || Hi !== old_hi || Lo !== old_lo) bad++;
            tick();
        end
        check({tag, "_inflight"}, 32'(bad), 32'd0);
        check({tag, "_done"}, {31'd0, Done}, 32'd1);
        check({tag, "_busy0"}, {31'd0, Busy}, 32'd0);
        check({tag, "_hi"}, Hi, eh);
        check({tag, "_lo"}, Lo, el);
        tick();
        check({tag, "_done_drop"}, {31'd0, Done}, 32'd0);
    endtask

    initial begin
        int bad;
        logic [31:0] hold_hi;

        tick();
        tick();
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_hi", Hi, 32'd0);
        check("rst_lo", Lo, 32'd0);
        RST = 1'b1;
        tick();

        issue(6'h11, 32'h12345678, 32'h0);
        check("mthi_hi", Hi, 32'h12345678);
        check("mthi_busy", {31'd0, Busy}, 32'd0);
        check("mthi_done", {31'd0, Done}, 32'd0);
        issue(6'h13, 32'hCAFEBABE, 32'h0);
        check("mtlo_lo", Lo, 32'hCAFEBABE);
        check("mtlo_hi", Hi, 32'h12345678);
        check("mtlo_busy", {31'd0, Busy}, 32'd0);
        check("mtlo_done", {31'd0, Done}, 32'd0);

        issue(6'h00, 32'h11111111, 32'h22222222);
        check("nop_busy", {31'd0, Busy}, 32'd0);
        check("nop_lo", Lo, 32'hCAFEBABE);

        run_op("multu_max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg",  6'h18, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("mult_nn",   6'h18, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006);
        run_op("multu_big", 6'h19, 32'h80000000, 32'h00000004, 32'h00000002, 32'h00000000);
        run_op("div_neg",   6'h1A, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_zero", 6'h1B, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF);
        run_op("div_zero",  6'h1A, 32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF);
        run_op("div_ovf",   6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op("divu_std",  6'h1B, 32'd1000,     32'd7,        32'd6,        32'd142);
        run_op("div_rneg",  6'h1A, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003);

        // MTHI while a DIV is in flight must be ignored.
        hold_hi = Hi;
        issue(6'h1A, 32'hFFFFFFF9, 32'd2);   // now in T+1
        for (int i = 0; i < 4; i++) tick(); // now in T+5
        issue(6'h11, 32'h0000DEAD, 32'h0);  // now in T+6
        check("busy_mthi_hi", Hi, hold_hi);
        check("busy_mthi_busy", {31'd0, Busy}, 32'd1);
        for (int i = 0; i < 28; i++) tick(); // now in T+34
        check("busy_div_done", {31'd0, Done}, 32'd1);
        check("busy_div_hi", Hi, 32'hFFFFFFFF);
        check("busy_div_lo", Lo, 32'hFFFFFFFD);

        // Back-to-back: MULT issued in the Done cycle.
        issue(6'h18, 32'd2, 32'd3);
        check("b2b_busy", {31'd0, Busy}, 32'd1);
        check("b2b_done_drop", {31'd0, Done}, 32'd0);
        for (int i = 0; i < 33; i++) tick();
        check("b2b_done", {31'd0, Done}, 32'd1);
        check("b2b_hi", Hi, 32'd0);
        check("b2b_lo", Lo, 32'd6);
        tick();

        // Reset mid-operation discards the multiply.
        issue(6'h18, 32'd5, 32'd5);          // now in T+1
        for (int i = 0; i < 9; i++) tick(); // now in T+10
        RST = 1'b0;
        tick();
        check("midrst_busy", {31'd0, Busy}, 32'd0);
        check("midrst_done", {31'd0, Done}, 32'd0);
        check("midrst_hi", Hi, 32'd0);
        check("midrst_lo", Lo, 32'd0);
        RST = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Done !== 1'b0 || Busy !== 1'b0 || Hi !== 32'd0 || Lo !== 32'd0) bad++;
        end
        check("midrst_no_commit", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
